// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready access channel and the id-routed read return.
// The arbiter takes the slave view; the requester group (or bench) takes the master view.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_REQ requesters; grant and BRAM drive are combinational (0-cycle issue),
// reads return RD_LATENCY cycles later routed by id; an ungranted requester just holds valid and waits.
module bram_port_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  ADDR_WIDTH = 13,
  parameter int  DATA_WIDTH = 32,
  parameter int  RD_LATENCY = 3,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            arb_mode,
  input  logic [ID_W-1:0]       sel_idx,
  bram_port_arbiter_if.slave    req_bus,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ID_W-1:0]       grant_idx,
  output logic                  busy
);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e     lock_state, lock_state_d;
  logic [ID_W-1:0] lock_owner, lock_owner_d;
  logic [ID_W-1:0] rr_ptr, rr_ptr_d;
  logic            lock_vld;

  logic            grant_vld;
  logic [ID_W-1:0] grant;
  int              rr_idx;
  logic            rd_fire;

  logic [RD_LATENCY-1:0]           pipe_vld;
  logic [RD_LATENCY-1:0][ID_W-1:0] pipe_id;
  logic                            resp_fire;
  logic [DATA_WIDTH-1:0]           resp_hold;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign lock_vld = (lock_state == LOCKED);

  // Grant selection; a held lock overrides arb_mode and sel_idx entirely.
  always_comb begin : grant_sel
    grant_vld = 1'b0;
    grant     = '0;
    rr_idx    = 0;
    if (!rst) begin
      if (lock_vld) begin
        if (req_bus.req_valid[lock_owner]) begin
          grant_vld = 1'b1;
          grant     = lock_owner;
        end
      end else begin
        case (arb_mode)
          MODE_STATIC: begin
            if (int'(sel_idx) < NUM_REQ) begin
              if (req_bus.req_valid[sel_idx]) begin
                grant_vld = 1'b1;
                grant     = sel_idx;
              end
            end
          end
          MODE_FIXED: begin
            // Scan high to low so the lowest valid index is the last writer.
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
              if (req_bus.req_valid[i]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(i);
              end
            end
          end
          MODE_RR: begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
              rr_idx = (int'(rr_ptr) + k) % NUM_REQ;
              if (req_bus.req_valid[rr_idx]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(rr_idx);
              end
            end
          end
          default: begin
            grant_vld = 1'b0;
          end
        endcase
      end
    end
  end

  assign req_bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant) : '0;
  assign grant_idx         = grant;

  always_comb begin : bram_drive
    bram_en   = grant_vld;
    bram_we   = grant_vld & req_bus.req_we[grant];
    bram_addr = '0;
    bram_din  = '0;
    if (grant_vld) begin
      bram_addr = req_bus.req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
      bram_din  = req_bus.req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_fire = grant_vld & ~req_bus.req_we[grant];

  // Lock FSM; rr_ptr is frozen while locked and restarts after the owner on release.
  always_comb begin : lock_next
    lock_state_d = lock_state;
    lock_owner_d = lock_owner;
    rr_ptr_d     = rr_ptr;
    case (lock_state)
      UNLOCKED: begin
        if (grant_vld) begin
          if (arb_mode == MODE_RR) begin
            rr_ptr_d = next_idx(grant);
          end
          if (req_bus.req_lock[grant]) begin
            lock_state_d = LOCKED;
            lock_owner_d = grant;
          end
        end
      end
      LOCKED: begin
        if (!req_bus.req_valid[lock_owner] ||
            (grant_vld && !req_bus.req_lock[lock_owner])) begin
          lock_state_d = UNLOCKED;
          rr_ptr_d     = next_idx(lock_owner);
        end
      end
      default: begin
        lock_state_d = UNLOCKED;
      end
    endcase
  end

  always_ff @(posedge clk) begin : lock_reg
    if (rst) begin
      lock_state <= UNLOCKED;
      lock_owner <= '0;
      rr_ptr     <= '0;
    end else begin
      lock_state <= lock_state_d;
      lock_owner <= lock_owner_d;
      rr_ptr     <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin : rd_pipe
    if (rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= rd_fire;
      pipe_id[0]  <= grant;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  assign resp_fire          = pipe_vld[RD_LATENCY-1] & ~rst;
  assign req_bus.resp_valid = resp_fire ? (NUM_REQ'(1) << pipe_id[RD_LATENCY-1]) : '0;

  // BRAM dout is only meaningful on the return cycle, so keep the last returned word.
  always_ff @(posedge clk) begin : resp_reg
    if (rst) begin
      resp_hold <= '0;
    end else if (resp_fire) begin
      resp_hold <= bram_dout;
    end
  end

  assign req_bus.resp_data = resp_fire ? bram_dout : resp_hold;
  assign busy              = lock_vld | (|pipe_vld);

endmodule
